// File: rtl/viterbi_pkg.sv
// Shared types and default sizing for the BER checker that sits behind the Viterbi decoder.
package viterbi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2,
    LOST   = 2'd3
  } ber_state_e;

  localparam int DEF_DEPTH = 64;
  localparam int DEF_WIN   = 32;
  localparam int DEF_THR   = 2;

endpackage

// File: rtl/ber_delay_line.sv
// Transmit-bit history: entry 0 is the newest bit, with one read tap selected by latency.
module ber_delay_line #(
  parameter int DEPTH = 64,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             din,
  input  logic [SEL_W-1:0] sel,
  output logic             tap
);

  logic [DEPTH-1:0] hist;

  // NOTE: the history is flops rather than RAM, so it gets a reset; a stale history
  // after reset would let a half-filled window align by accident.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
    end else if (shift_en) begin
      hist <= {hist[DEPTH-2:0], din};
    end
  end

  // The tap is read before the same-cycle shift lands.
  assign tap = hist[sel];

endmodule

// File: rtl/ber_checker.sv
// Bit-error-rate checker: searches for the tx->rx latency, locks, then counts bit errors.
// Optional lock-loss detection in LOCKED is enabled by defining BER_LOSS_DETECT_EN.
module ber_checker
  import viterbi_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIN   = DEF_WIN,
  parameter int THR   = DEF_THR,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tx_bit_i,
  input  logic                     tx_valid_i,
  input  logic                     rx_bit_i,
  input  logic                     rx_valid_i,
  input  logic                     clear_i,
  output logic                     locked_o,
  output logic [$clog2(DEPTH)-1:0] latency_o,
  output logic [CNT_W-1:0]         bit_cnt_o,
  output logic [CNT_W-1:0]         err_cnt_o,
  output logic [1:0]               state_o
);

  localparam int                LAT_W   = $clog2(DEPTH);
  localparam int                WC_W    = $clog2(WIN + 1);
  localparam logic [WC_W-1:0]   WIN_C   = WC_W'(WIN);
  localparam logic [WC_W-1:0]   THR_C   = WC_W'(THR);
  localparam logic [LAT_W-1:0]  LAT_MAX = LAT_W'(DEPTH - 1);

  ber_state_e        state_q, state_d;
  logic [LAT_W-1:0]  latency_q, latency_inc;
  logic [WC_W-1:0]   win_q, mis_q, win_nxt, mis_nxt;
  logic [CNT_W-1:0]  bit_q, err_q;
  logic              tap, mismatch, window_done, window_bad;

  ber_delay_line #(.DEPTH(DEPTH), .SEL_W(LAT_W)) u_hist (
    .clk      (clk),
    .rst      (rst),
    .shift_en (tx_valid_i),
    .din      (tx_bit_i),
    .sel      (latency_q),
    .tap      (tap)
  );

  assign mismatch    = rx_bit_i ^ tap;
  assign win_nxt     = win_q + WC_W'(1);
  assign mis_nxt     = mis_q + WC_W'(mismatch);
  assign window_done = rx_valid_i && (win_nxt == WIN_C);
  assign window_bad  = mis_nxt > THR_C;
  assign latency_inc = (latency_q == LAT_MAX) ? '0 : latency_q + LAT_W'(1);

  // NOTE: sequential state is written with <= only, so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets its default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = SEARCH;
    end else begin
      case (state_q)
        IDLE:    if (tx_valid_i) state_d = SEARCH;
        SEARCH:  if (window_done && !window_bad) state_d = LOCKED;
`ifdef BER_LOSS_DETECT_EN
        LOCKED:  if (window_done && window_bad) state_d = LOST;
`else
        LOCKED:  state_d = LOCKED;
`endif
        LOST:    state_d = SEARCH;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    locked_o = (state_q == LOCKED);
    state_o  = state_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      latency_q <= '0;
      win_q     <= '0;
      mis_q     <= '0;
      bit_q     <= '0;
      err_q     <= '0;
    end else if (clear_i) begin
      win_q <= '0;
      mis_q <= '0;
      bit_q <= '0;
      err_q <= '0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (rx_valid_i) begin
            if (window_done) begin
              win_q <= '0;
              mis_q <= '0;
              if (window_bad) latency_q <= latency_inc;
            end else begin
              win_q <= win_nxt;
              mis_q <= mis_nxt;
            end
          end
        end
        LOCKED: begin
          if (rx_valid_i) begin
            if (bit_q != '1) bit_q <= bit_q + CNT_W'(1);
            if (mismatch && (err_q != '1)) err_q <= err_q + CNT_W'(1);
`ifdef BER_LOSS_DETECT_EN
            // Non-overlapping windows: restart the window after every WIN compares.
            if (window_done) begin
              win_q <= '0;
              mis_q <= '0;
            end else begin
              win_q <= win_nxt;
              mis_q <= mis_nxt;
            end
`endif
          end
        end
        LOST: begin
          win_q     <= '0;
          mis_q     <= '0;
          latency_q <= latency_inc;
        end
        default: ;
      endcase
    end
  end

  assign latency_o = latency_q;
  assign bit_cnt_o = bit_q;
  assign err_cnt_o = err_q;

endmodule

// File: tb/tb_ber_checker.sv
// Scoreboard bench for ber_checker: stimulus queues expected snapshots and lock latencies,
// independent monitors compare them against the DUT outputs.
module tb_ber_checker;

  typedef logic [72:0] vec_t;

  typedef struct {
    string       name;
    logic [1:0]  st;
    logic        lk;
    logic [5:0]  lat;
    logic [31:0] bits;
    logic [31:0] errs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_bit = 1'b0, tx_valid = 1'b0;
  logic        rx_bit = 1'b0, rx_valid = 1'b0;
  logic        clear = 1'b0;
  logic        locked;
  logic [5:0]  latency;
  logic [31:0] bit_cnt, err_cnt;
  logic [1:0]  state;

  exp_t        exp_q[$];
  int          lock_q[$];
  int          checks = 0;
  int          failures = 0;
  event        sample_ev;

  logic [6:0]  prbs = 7'h7F;
  logic [63:0] mh = '0;
  int          delay = 0;
  int          n;

  ber_checker dut (
    .clk        (clk),
    .rst        (rst),
    .tx_bit_i   (tx_bit),
    .tx_valid_i (tx_valid),
    .rx_bit_i   (rx_bit),
    .rx_valid_i (rx_valid),
    .clear_i    (clear),
    .locked_o   (locked),
    .latency_o  (latency),
    .bit_cnt_o  (bit_cnt),
    .err_cnt_o  (err_cnt),
    .state_o    (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input vec_t got, input vec_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Snapshot monitor: {state, locked, latency, bit_cnt, err_cnt}.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, {state, locked, latency, bit_cnt, err_cnt},
              {e.st, e.lk, e.lat, e.bits, e.errs});
      end
    end
  end

  // Lock monitor: every rising locked must match the next expected latency.
  initial begin
    forever begin
      @(posedge locked);
      #1;
      if (lock_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_lock got latency=%0d exp=no lock", latency);
      end else begin
        check("lock_latency", vec_t'(latency), vec_t'(lock_q.pop_front()));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_now(input string nm, input logic [1:0] st, input logic lk,
                            input int lat, input int bits, input int errs);
    exp_q.push_back(exp_t'{nm, st, lk, 6'(lat), 32'(bits), 32'(errs)});
    -> sample_ev;
    #1;
  endtask

  // rx follows history entry `delay` of the bench's own tx model (entry 0 = previous tx bit).
  task automatic step(input bit txv, input bit rxv, input bit flip, input bit clr);
    logic b;
    tx_valid = txv;
    rx_valid = rxv;
    clear    = clr;
    rx_bit   = mh[delay] ^ flip;
    if (txv) begin
      b      = prbs[6] ^ prbs[5];
      prbs   = {prbs[5:0], b};
      tx_bit = b;
      mh     = {mh[62:0], b};
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    rx_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic run_until_lock(input int max, output int cnt);
    cnt = 0;
    while (!locked && cnt < max) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      cnt++;
    end
  endtask

  initial begin
    #3;
    expect_now("reset_state", 2'd0, 1'b0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Alignment: true delay 20, 20 failing trials then a passing one, plus the IDLE cycle.
    delay = 20;
    lock_q.push_back(20);
    run_until_lock(700, n);
    check("t1_cycles", vec_t'(n), vec_t'(673));
    expect_now("t1_locked", 2'd2, 1'b1, 20, 0, 0);

`ifdef BER_LOSS_DETECT_EN
    for (int i = 0; i < 320; i++) step(1'b1, 1'b1, (i % 32 == 5) || (i % 32 == 20), 1'b0);
    expect_now("t2_counts", 2'd2, 1'b1, 20, 320, 20);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, i < 8, 1'b0);
    expect_now("t3_lost", 2'd3, 1'b0, 20, 352, 28);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_now("t3_search", 2'd1, 1'b0, 21, 352, 28);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    expect_now("t4_clear", 2'd1, 1'b0, 21, 0, 0);
`else
    for (int i = 0; i < 340; i++) step(1'b1, 1'b1, (i % 17) < 4, 1'b0);
    expect_now("t2_counts", 2'd2, 1'b1, 20, 340, 80);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b1, i < 8, 1'b0);
    expect_now("t3_hold", 2'd2, 1'b1, 20, 372, 88);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    expect_now("t4_clear", 2'd1, 1'b0, 20, 0, 0);
`endif

    // Reset between edges clears everything, including the history.
    rst = 1'b0;
    #1;
    expect_now("t5_reset", 2'd0, 1'b0, 0, 0, 0);
    mh = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // rx alone does not leave IDLE.
    delay = 5;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    expect_now("t5_idle_rx", 2'd0, 1'b0, 0, 0, 0);

    lock_q.push_back(5);
    run_until_lock(300, n);
    check("t5_cycles", vec_t'(n), vec_t'(193));
    expect_now("t5_lock5", 2'd2, 1'b1, 5, 0, 0);

    // Wrap-around: from latency 5 with true delay 2, trials 5..63, 0, 1, 2.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    delay = 2;
    lock_q.push_back(2);
    run_until_lock(2100, n);
    check("t5_wrap_cycles", vec_t'(n), vec_t'(62 * 32));
    expect_now("t5_wrap", 2'd2, 1'b1, 2, 0, 0);

    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, (i == 1) || (i == 4) || (i == 7), 1'b0);
    expect_now("t6_counts", 2'd2, 1'b1, 2, 10, 3);
    #2;
    rst = 1'b0;
    #1;
    expect_now("t6_async_reset", 2'd0, 1'b0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    check("lock_q_drained", vec_t'(lock_q.size()), vec_t'(0));
    check("exp_q_drained", vec_t'(exp_q.size()), vec_t'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ber_checker.md
BER_CHECKER -- requirements
Module: ber_checker

Interface
REQ-001 Parameter DEPTH, default 64: tx history depth in bits; candidate latencies 0..DEPTH-1.
REQ-002 Parameter WIN, default 32: compared bits per alignment trial and per loss-detect window.
REQ-003 Parameter THR, default 2: maximum mismatches in a window that still count as aligned.
REQ-004 Parameter CNT_W, default 32: width of the bit and error counters.
REQ-005 clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous assert, active-low; all state clears while low.
REQ-007 tx_bit_i  in  1  source bit as fed to the encoder.
REQ-008 tx_valid_i  in  1  tx_bit_i is a new source bit this cycle.
REQ-009 rx_bit_i  in  1  decoded bit from the Viterbi decoder.
REQ-010 rx_valid_i  in  1  rx_bit_i is a new decoded bit this cycle.
REQ-011 clear_i  in  1  synchronous clear of counters and return to SEARCH.
REQ-012 locked_o  out  1  high while in state LOCKED.
REQ-013 latency_o  out  $clog2(DEPTH)  current candidate or locked latency, in tx bits.
REQ-014 bit_cnt_o  out  CNT_W  bits compared while LOCKED.
REQ-015 err_cnt_o  out  CNT_W  mismatches counted while LOCKED.
REQ-016 state_o  out  2  encoded FSM state.

Function
REQ-017 History: on tx_valid_i, shift tx_bit_i into entry 0; older entries move up one place; the entry at DEPTH-1 is dropped.
REQ-018 Compare on rx_valid_i only: rx_bit_i against history entry latency_o, using the value held before any same-cycle shift; mismatch = XOR.
REQ-019 FSM states: IDLE=0, SEARCH=1, LOCKED=2, LOST=3.
REQ-020 IDLE -> SEARCH on the first tx_valid_i after reset.
REQ-021 SEARCH: a trial is WIN compares on one latency; a window counter and a mismatch counter run per trial.
REQ-022 SEARCH, trial end with mismatches <= THR: go to LOCKED next cycle and keep latency_o.
REQ-023 SEARCH, trial end with mismatches > THR: latency_o increments and wraps DEPTH-1 -> 0; the window and mismatch counters clear.
REQ-024 LOCKED: each compare increments bit_cnt_o; each mismatch also increments err_cnt_o; both saturate at all-ones.
REQ-025 bit_cnt_o and err_cnt_o hold their values outside LOCKED.
REQ-026 Counters become visible 1 cycle after the compare cycle.
REQ-027 LOST: one cycle only; window counters clear; latency_o increments with wrap; next state is SEARCH.
REQ-028 clear_i has priority over all other events in the same cycle; state becomes SEARCH, counters go to 0, latency_o is kept.
REQ-029 rx_valid_i without a preceding tx_valid_i compares against reset history (all 0); no special case.

Reset
REQ-030 While rst is low: state IDLE, history all 0, latency_o=0, locked_o=0, bit_cnt_o=0, err_cnt_o=0, state_o=0.
REQ-031 Reset asserted mid-trial or while LOCKED discards all progress; no partial window survives.

Configuration
REQ-032 Macro BER_LOSS_DETECT_EN, when defined: in LOCKED, consecutive non-overlapping WIN-compare windows are checked, and a window with more than THR mismatches moves the state to LOST.
REQ-033 Without BER_LOSS_DETECT_EN: LOCKED is left only by clear_i or reset, and state LOST is unreachable.

Structure
REQ-034 Package viterbi_pkg holds the state enum and the default DEPTH, WIN and THR constants.
REQ-035 Sub-module ber_delay_line holds the shift-register history with a selectable read tap; all other logic lives in ber_checker.

Verification
REQ-036 Alignment: PRBS7 on tx, rx = tx delayed by 20 valid bits, no errors -> locked_o=1 with latency_o=20 within 21*32 compares; err_cnt_o=0.
REQ-037 Error counting: locked, invert 4 of every 17 rx bits over 340 compares -> bit_cnt_o=340, err_cnt_o=80.
REQ-038 Wrap-around: true delay 2 while starting at latency 5 -> trials run 5..63, 0, 1, 2; lock at latency_o=2.
REQ-039 Loss of lock (macro on): locked, then 8 consecutive rx inversions in one window -> state_o passes through 3, locked_o=0, SEARCH restarts at latency+1; macro off -> stays LOCKED and err_cnt_o increases by 8.
REQ-040 Clear and reset: clear_i together with rx_valid_i mismatch -> counters 0 and state SEARCH; rst pulled low mid-LOCKED -> all outputs 0 immediately, without waiting for a clk edge.
